cpu_control_unit: RTL

Multicycle fetch/decode/execute controller for the 8-bit CPU. It owns the PC, the instruction register and a 4x8-bit register file. It sequences the external 8-bit ALU (opcode 000 = add, 001 = subtract, combinational result plus zero flag). Instructions come from an asynchronous-read instruction ROM addressed by pc.

---
 rtl/cpu_control_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Multicycle fetch/decode/execute controller for the 8-bit CPU.
// Owns PC, IR, a 4x8 register file and sequences an external combinational ALU.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] pc,
  input  logic [7:0] instr_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       zero_flag,
  output logic       halted,
  output logic [7:0] r0_out,
  output logic [2:0] state_out
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] FETCH_IMM = 3'd2;
  localparam logic [2:0] EXEC      = 3'd3;
  localparam logic [2:0] WB        = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_MOV  = 3'b011;
  localparam logic [2:0] OP_JZ   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [2:0]      state;
  logic [7:0]      ir;
  logic [7:0]      tmp;
  logic [3:0][7:0] regs;
  logic [2:0]      op;
  logic [1:0]      rd, rs;

  assign op = ir[7:5];
  assign rd = ir[4:3];
  assign rs = ir[2:1];

  assign alu_a      = regs[rd];
  assign alu_b      = regs[rs];
  assign alu_opcode = (state == EXEC) ? op : 3'b000;
  assign r0_out     = regs[0];
  assign state_out  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      tmp       <= 8'h00;
      regs      <= '0;
      zero_flag <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ir    <= instr_data;
            pc    <= pc + 8'd1;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_ADD, OP_SUB:        state <= EXEC;
            OP_LDI, OP_JZ, OP_JMP: state <= FETCH_IMM;
            OP_MOV:                state <= WB;
            OP_NOP:                state <= FETCH;
            OP_HALT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default:               state <= FETCH;
          endcase
        end
        FETCH_IMM: begin
          state <= FETCH;
          case (op)
            OP_LDI: begin
              tmp   <= instr_data;
              pc    <= pc + 8'd1;
              state <= WB;
            end
            OP_JMP:  pc <= instr_data;
            OP_JZ:   pc <= zero_flag ? instr_data : pc + 8'd1;
            default: pc <= pc + 8'd1;
          endcase
        end
        EXEC: begin
          tmp       <= alu_result;
          zero_flag <= alu_zero;
          state     <= WB;
        end
        WB: begin
          // MOV bypasses TMP and copies the source register directly
          regs[rd] <= (op == OP_MOV) ? regs[rs] : tmp;
          state    <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
